spi_slave_core: RTL and testbench

SPI slave front end between the GPIO-extender pins (SCK, SSEL, MOSI, MISO) and the downstream command decoder, all in the 16 MHz `CLK` domain. It synchronises the asynchronous SPI pins, detects SCK edges, deserialises MOSI into bytes and serialises a response byte onto MISO. It presents a byte stream with per-frame markers to the decoder and requests reply bytes from it.

---
 rtl/spi_pkg.sv | 16 +
 rtl/sync_edge.sv | 32 +++
 rtl/spi_slave_core.sv | 157 +++++++++++++++
 tb/tb_spi_slave_core.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave front end.
// Mode 3 only: SCK idles high, sample on rise, drive on fall.
package spi_pkg;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;

   localparam bit SPI_CPOL = 1'b1;
   localparam bit SPI_CPHA = 1'b1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Pin synchroniser with a history flop for rise/fall strobes.
// INIT sets the level the chain assumes while in reset.
module sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{INIT}};
         hist_q <= INIT;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-3 slave: pin sync, byte deserialiser and reply serialiser
// feeding a command decoder with per-frame markers.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCK,
   input  logic              SSEL,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_first,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ack,
   output logic              frame_start,
   output logic              frame_end,
   output logic              rx_abort
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic sck_s, sck_rise, sck_fall;
   logic ssel_s, ssel_rise, ssel_fall;
   logic mosi_s, unused_mosi_rise, unused_mosi_fall;
   logic unused_sck_s, unused_ssel_s;

   state_t            state;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     cnt_nxt;
   logic              word_done;
   logic              first_q;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_word;
   logic [DATA_W-1:0] tx_shift;
   logic              miso_q;
   logic              oe_q;

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sck (
      .clk   (CLK),
      .rst   (RST),
      .d     (SCK),
      .level (sck_s),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   // SSEL resets low so a frame already in progress at reset
   // release is not mistaken for a fresh SSEL fall.
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_ssel (
      .clk   (CLK),
      .rst   (RST),
      .d     (SSEL),
      .level (ssel_s),
      .rise  (ssel_rise),
      .fall  (ssel_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
      .clk   (CLK),
      .rst   (RST),
      .d     (MOSI),
      .level (mosi_s),
      .rise  (unused_mosi_rise),
      .fall  (unused_mosi_fall)
   );

   assign unused_sck_s  = sck_s;
   assign unused_ssel_s = ssel_s;

   assign word_done = sck_rise && (bit_cnt == LAST);
   assign rx_word   = {rx_shift[DATA_W-2:0], mosi_s};

   always_comb begin
      cnt_nxt = bit_cnt;
      if (sck_rise)
         cnt_nxt = word_done ? '0 : bit_cnt + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         first_q     <= 1'b0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_first    <= 1'b0;
         tx_ack      <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         rx_abort    <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_ack      <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         rx_abort    <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (ssel_fall) begin
                  state       <= ST_SHIFT;
                  frame_start <= 1'b1;
                  bit_cnt     <= '0;
                  first_q     <= 1'b1;
                  oe_q        <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (sck_rise) begin
                  rx_shift <= rx_word;
                  bit_cnt  <= cnt_nxt;
                  if (word_done) begin
                     rx_data  <= rx_word;
                     rx_valid <= 1'b1;
                     rx_first <= first_q;
                     first_q  <= 1'b0;
                  end
               end
               if (sck_fall) begin
                  if (bit_cnt == '0) begin
                     miso_q   <= tx_data[DATA_W-1];
                     tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                     tx_ack   <= 1'b1;
                  end else begin
                     miso_q   <= tx_shift[DATA_W-1];
                     tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  end
               end
               // End of frame after any same-cycle rising edge.
               if (ssel_rise) begin
                  state     <= ST_IDLE;
                  frame_end <= 1'b1;
                  rx_abort  <= (cnt_nxt != '0);
                  bit_cnt   <= '0;
                  miso_q    <= 1'b0;
                  oe_q      <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign MISO    = miso_q & oe_q;
   assign MISO_OE = oe_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a mode-3 master model drives the pins,
// a monitor logs decoder-side pulses, tasks compare to the master view.
`timescale 1ns/1ps
module tb_spi_slave_core;

   localparam int H = 8;

   logic       CLK = 1'b0;
   logic       RST;
   logic       SCK;
   logic       SSEL;
   logic       MOSI;
   logic       MISO;
   logic       MISO_OE;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_first;
   logic [7:0] tx_data;
   logic       tx_ack;
   logic       frame_start;
   logic       frame_end;
   logic       rx_abort;

   int tests = 0;
   int fails = 0;
   int fs_n = 0;
   int fe_n = 0;
   int ab_n = 0;
   int ack_n = 0;
   int tx_idx = 0;

   logic [8:0] rxq[$];
   logic [7:0] mb[16];
   logic [7:0] txv[16];
   logic [7:0] mr[16];

   spi_slave_core dut (
      .CLK         (CLK),
      .RST         (RST),
      .SCK         (SCK),
      .SSEL        (SSEL),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .MISO_OE     (MISO_OE),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_first    (rx_first),
      .tx_data     (tx_data),
      .tx_ack      (tx_ack),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .rx_abort    (rx_abort)
   );

   always #31.25 CLK = ~CLK;

   // Decoder model: logs words and frame markers, feeds replies.
   always @(negedge CLK) begin
      if (rx_valid) rxq.push_back({rx_first, rx_data});
      if (frame_start) fs_n++;
      if (frame_end) fe_n++;
      if (rx_abort) ab_n++;
      if (tx_ack) begin
         ack_n++;
         tx_idx++;
         tx_data = txv[tx_idx % 16];
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic arm_tx();
      tx_idx = 0;
      tx_data = txv[0];
      rxq.delete();
   endtask

   // Mode-3 master: drive on SCK fall, sample MISO at SCK rise.
   task automatic run_frame(input int nb, input int part, input bit co);
      int nbits;
      nbits = nb * 8 + part;
      SSEL = 1'b0;
      idle(10);
      for (int k = 0; k < nbits; k++) begin
         SCK = 1'b0;
         MOSI = mb[k / 8][7 - (k % 8)];
         idle(H);
         SCK = 1'b1;
         if (co && k == nbits - 1) SSEL = 1'b1;
         mr[k / 8][7 - (k % 8)] = MISO;
         idle(H);
      end
      if (!co) begin
         idle(4);
         SSEL = 1'b1;
      end
      idle(12);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      SCK = 1'b1;
      SSEL = 1'b1;
      MOSI = 1'b0;
      tx_data = 8'h00;
      idle(3);
      tests++;
      if ({MISO, MISO_OE} !== 2'b00) begin
         fails++;
         $display("FAIL reset_miso: got %b expected 00", {MISO, MISO_OE});
      end
      tests++;
      if (rx_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      end
      tests++;
      if ({rx_valid, tx_ack, frame_start, frame_end, rx_abort} !== 5'b0) begin
         fails++;
         $display("FAIL reset_pulses: got %b expected 00000",
                  {rx_valid, tx_ack, frame_start, frame_end, rx_abort});
      end
      RST = 1'b0;
      idle(10);
      tests++;
      if (fs_n + fe_n + ab_n !== 0) begin
         fails++;
         $display("FAIL reset_release_markers: got %0d expected 0",
                  fs_n + fe_n + ab_n);
      end
   endtask

   task automatic test_single();
      int fs0, fe0, ab0;
      fs0 = fs_n; fe0 = fe_n; ab0 = ab_n;
      mb[0] = 8'hA5;
      txv[0] = 8'h00;
      arm_tx();
      run_frame(1, 0, 1'b0);
      tests++;
      if (rxq.size() !== 1 || rxq[0] !== {1'b1, 8'hA5}) begin
         fails++;
         $display("FAIL single_rx: got n=%0d w=%h expected n=1 w=1a5",
                  rxq.size(), (rxq.size() > 0) ? rxq[0] : 9'h0);
      end
      tests++;
      if ({fs_n - fs0, fe_n - fe0, ab_n - ab0} !== {32'd1, 32'd1, 32'd0}) begin
         fails++;
         $display("FAIL single_markers: got fs=%0d fe=%0d ab=%0d expected 1 1 0",
                  fs_n - fs0, fe_n - fe0, ab_n - ab0);
      end
   endtask

   task automatic test_multi();
      int a0;
      a0 = ack_n;
      mb[0] = 8'h01; mb[1] = 8'h80; mb[2] = 8'hFF;
      txv[0] = 8'h3C; txv[1] = 8'hC3; txv[2] = 8'h5A; txv[3] = 8'h00;
      arm_tx();
      run_frame(3, 0, 1'b0);
      tests++;
      if (rxq.size() !== 3) begin
         fails++;
         $display("FAIL multi_count: got %0d expected 3", rxq.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < rxq.size()) begin
            tests++;
            if (rxq[i] !== {(i == 0), mb[i]}) begin
               fails++;
               $display("FAIL multi_rx%0d: got %h expected %h",
                        i, rxq[i], {(i == 0), mb[i]});
            end
         end
         tests++;
         if (mr[i] !== txv[i]) begin
            fails++;
            $display("FAIL multi_miso%0d: got %h expected %h", i, mr[i], txv[i]);
         end
      end
      tests++;
      if (ack_n - a0 !== 3) begin
         fails++;
         $display("FAIL multi_ack: got %0d expected 3", ack_n - a0);
      end
   endtask

   task automatic test_abort();
      int fe0, ab0;
      fe0 = fe_n; ab0 = ab_n;
      mb[0] = 8'($urandom);
      arm_tx();
      run_frame(0, 5, 1'b0);
      tests++;
      if ({ab_n - ab0, fe_n - fe0, rxq.size()} !== {32'd1, 32'd1, 32'd0}) begin
         fails++;
         $display("FAIL abort: got ab=%0d fe=%0d rx=%0d expected 1 1 0",
                  ab_n - ab0, fe_n - fe0, rxq.size());
      end
      mb[0] = 8'h42;
      arm_tx();
      run_frame(1, 0, 1'b0);
      tests++;
      if (rxq.size() !== 1 || rxq[0] !== {1'b1, 8'h42}) begin
         fails++;
         $display("FAIL abort_next: got n=%0d w=%h expected n=1 w=142",
                  rxq.size(), (rxq.size() > 0) ? rxq[0] : 9'h0);
      end
   endtask

   task automatic test_coincide();
      int fe0, ab0;
      logic [7:0] b;
      fe0 = fe_n; ab0 = ab_n;
      b = 8'($urandom);
      mb[0] = b;
      arm_tx();
      run_frame(1, 0, 1'b1);
      tests++;
      if (rxq.size() !== 1 || rxq[0] !== {1'b1, b}) begin
         fails++;
         $display("FAIL coincide_rx: got n=%0d w=%h expected n=1 w=%h",
                  rxq.size(), (rxq.size() > 0) ? rxq[0] : 9'h0, {1'b1, b});
      end
      tests++;
      if ({fe_n - fe0, ab_n - ab0} !== {32'd1, 32'd0}) begin
         fails++;
         $display("FAIL coincide_markers: got fe=%0d ab=%0d expected 1 0",
                  fe_n - fe0, ab_n - ab0);
      end
   endtask

   task automatic test_idle_sck();
      int a0;
      int bad;
      a0 = ack_n;
      bad = 0;
      rxq.delete();
      for (int i = 0; i < 10; i++) begin
         SCK = 1'b0;
         MOSI = 1'($urandom);
         idle(H);
         if ({MISO, MISO_OE} !== 2'b00) bad++;
         SCK = 1'b1;
         idle(H);
         if ({MISO, MISO_OE} !== 2'b00) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL idle_miso: got %0d nonzero samples expected 0", bad);
      end
      tests++;
      if ({rxq.size(), ack_n - a0} !== {32'd0, 32'd0}) begin
         fails++;
         $display("FAIL idle_activity: got rx=%0d ack=%0d expected 0 0",
                  rxq.size(), ack_n - a0);
      end
   endtask

   task automatic test_reset_mid();
      int fs0;
      SSEL = 1'b0;
      idle(10);
      for (int k = 0; k < 3; k++) begin
         SCK = 1'b0;
         MOSI = 1'b1;
         idle(H);
         SCK = 1'b1;
         idle(H);
      end
      RST = 1'b1;
      #1;
      tests++;
      if ({MISO, MISO_OE, rx_valid, tx_ack, frame_end, rx_abort} !== 6'b0) begin
         fails++;
         $display("FAIL rst_mid_async: got %b expected 000000",
                  {MISO, MISO_OE, rx_valid, tx_ack, frame_end, rx_abort});
      end
      idle(3);
      RST = 1'b0;
      fs0 = fs_n;
      idle(12);
      tests++;
      if ({fs_n - fs0, 31'd0, MISO_OE} !== 64'd0) begin
         fails++;
         $display("FAIL rst_mid_wait: got fs=%0d oe=%b expected 0 0",
                  fs_n - fs0, MISO_OE);
      end
      SSEL = 1'b1;
      idle(12);
      mb[0] = 8'h96;
      arm_tx();
      run_frame(1, 0, 1'b0);
      tests++;
      if (rxq.size() !== 1 || rxq[0] !== {1'b1, 8'h96}) begin
         fails++;
         $display("FAIL rst_mid_frame: got n=%0d w=%h expected n=1 w=196",
                  rxq.size(), (rxq.size() > 0) ? rxq[0] : 9'h0);
      end
   endtask

   task automatic test_random();
      int nb, ab0;
      for (int f = 0; f < 4; f++) begin
         nb = int'($urandom_range(1, 4));
         for (int i = 0; i < 16; i++) begin
            mb[i] = 8'($urandom);
            txv[i] = 8'($urandom);
         end
         ab0 = ab_n;
         arm_tx();
         run_frame(nb, 0, 1'b0);
         tests++;
         if ({rxq.size(), ab_n - ab0} !== {nb, 32'd0}) begin
            fails++;
            $display("FAIL rand%0d_count: got rx=%0d ab=%0d expected %0d 0",
                     f, rxq.size(), ab_n - ab0, nb);
         end
         for (int i = 0; i < nb; i++) begin
            if (i < rxq.size()) begin
               tests++;
               if (rxq[i] !== {(i == 0), mb[i]}) begin
                  fails++;
                  $display("FAIL rand%0d_rx%0d: got %h expected %h",
                           f, i, rxq[i], {(i == 0), mb[i]});
               end
            end
            tests++;
            if (mr[i] !== txv[i]) begin
               fails++;
               $display("FAIL rand%0d_miso%0d: got %h expected %h",
                        f, i, mr[i], txv[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_abort();
      test_coincide();
      test_idle_sck();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
